// File: rtl/pll_lock_supervisor.sv
// Power-up sequencer for the rPLL: holds the PLL in reset, qualifies LOCK, retries on
// timeout and releases the PLL-domain system reset once lock has been stable long enough.
module pll_lock_supervisor #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_raw,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               sync1_q, lock_s_q;
  logic               pll_reset_q, sys_rst_n_q, locked_q, fail_q;

  // Two-flop synchronizer for the asynchronous PLL LOCK output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= lock_raw;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic; restart overrides every other transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PLL_RST;
              retry_d = retry_q + RETRY_W'(1);
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STAB_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lock_s_q) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            if (loss_q != LOSS_SAT) begin
              loss_d = loss_q + LOSS_W'(1);
            end
          end
        end
        ST_FAIL: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are flopped decodes of the next state so they track state_q exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_reset_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      sys_rst_n_q <= (state_d == ST_RUN);
      locked_q    <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, multi-cycle corner sequences and
// randomized lock/restart traffic against a deadline-based reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned LS = 8;
  localparam int unsigned MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lock_raw = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, sys_rst_n, locked, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_fail = 0;

  pll_lock_supervisor #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRIES(MR), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lock_raw(lock_raw), .restart(restart),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: phases with absolute edge deadlines; lock seen two edges late
  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mphase_e;
  mphase_e m_ph;
  int      m_t, m_dl, m_retry, m_loss;
  bit      m_hist[$];

  function automatic void model_reset();
    m_t = 0; m_ph = M_RST; m_dl = RC; m_retry = 0; m_loss = 0;
    m_hist = {};
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit ls;
    m_t++;
    ls = m_hist.pop_front();
    m_hist.push_back(lock_raw);
    if (restart) begin
      m_ph = M_RST; m_dl = m_t + RC; m_retry = 0;
    end else begin
      case (m_ph)
        M_RST: if (m_t == m_dl) begin m_ph = M_WAIT; m_dl = m_t + LT; end
        M_WAIT: begin
          if (ls) begin
            m_ph = M_STAB; m_dl = m_t + LS;
          end else if (m_t == m_dl) begin
            if (m_retry == MR) m_ph = M_FAIL;
            else begin m_retry++; m_ph = M_RST; m_dl = m_t + RC; end
          end
        end
        M_STAB: begin
          if (!ls) begin m_ph = M_WAIT; m_dl = m_t + LT; end
          else if (m_t == m_dl) begin m_ph = M_RUN; m_retry = 0; end
        end
        M_RUN: if (!ls) begin
          m_ph = M_RST; m_dl = m_t + RC;
          if (m_loss < 255) m_loss++;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_compare();
    chk("m_pll_reset", int'(pll_reset), int'(m_ph == M_RST || m_ph == M_FAIL));
    chk("m_sys_rst_n", int'(sys_rst_n), int'(m_ph == M_RUN));
    chk("m_locked",    int'(locked),    int'(m_ph == M_RUN));
    chk("m_fail",      int'(fail),      int'(m_ph == M_FAIL));
    chk("m_retry",     int'(retry_cnt), m_retry);
    chk("m_loss",      int'(loss_cnt),  m_loss);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    model_compare();
  endtask

  // Asynchronous reset: outputs must reach reset values with no clock edge in between
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pll_reset", int'(pll_reset), 1);
    chk("rst_sys_rst_n", int'(sys_rst_n), 0);
    chk("rst_locked",    int'(locked),    0);
    chk("rst_fail",      int'(fail),      0);
    chk("rst_retry",     int'(retry_cnt), 0);
    chk("rst_loss",      int'(loss_cnt),  0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst; bit lock; bit rs; int n;
    bit p; bit s; bit l; bit f; int r; int loss;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit rst, bit lock, bit rs, int n,
                              bit p, bit s, bit l, bit f, int r, int loss);
    vec_t v;
    v.rst = rst; v.lock = lock; v.rs = rs; v.n = n;
    v.p = p; v.s = s; v.l = l; v.f = f; v.r = r; v.loss = loss;
    vecs.push_back(v);
  endfunction

  initial begin
    int run_left;
    bit ok;
    model_reset();

    // Nominal lock, lock loss, re-lock, restart colliding with lock loss
    add(1,0,0, 3, 1,0,0,0,0,0);  // edge 3
    add(0,0,0, 1, 0,0,0,0,0,0);  // edge 4
    add(0,0,0, 5, 0,0,0,0,0,0);  // edge 9
    add(0,1,0,10, 0,0,0,0,0,0);  // edge 19
    add(0,1,0, 1, 0,1,1,0,0,0);  // edge 20
    add(0,0,0, 2, 0,1,1,0,0,0);  // edge 22
    add(0,0,0, 1, 1,0,0,0,0,1);  // edge 23
    add(0,1,0, 3, 1,0,0,0,0,1);  // edge 26
    add(0,1,0, 1, 0,0,0,0,0,1);  // edge 27
    add(0,1,0, 8, 0,0,0,0,0,1);  // edge 35
    add(0,1,0, 1, 0,1,1,0,0,1);  // edge 36
    add(0,0,0, 2, 0,1,1,0,0,1);  // edge 38
    add(0,0,1, 1, 1,0,0,0,0,1);  // edge 39: restart wins over loss
    add(0,0,0, 3, 1,0,0,0,0,1);
    add(0,0,0, 1, 0,0,0,0,0,1);
    // No lock: two retries then FAIL, then restart
    add(1,0,0, 4, 0,0,0,0,0,0);
    add(0,0,0,19, 0,0,0,0,0,0);
    add(0,0,0, 1, 1,0,0,0,1,0);  // edge 24
    add(0,0,0, 4, 0,0,0,0,1,0);
    add(0,0,0,20, 1,0,0,0,2,0);  // edge 48
    add(0,0,0, 4, 0,0,0,0,2,0);
    add(0,0,0,19, 0,0,0,0,2,0);  // edge 71
    add(0,0,0, 1, 1,0,0,1,2,0);  // edge 72
    add(0,0,0,10, 1,0,0,1,2,0);
    add(0,0,1, 1, 1,0,0,0,0,0);
    add(0,0,0, 3, 1,0,0,0,0,0);
    add(0,0,0, 1, 0,0,0,0,0,0);
    // One-cycle glitch in STABLE
    add(1,1,0, 9, 0,0,0,0,0,0);
    add(0,0,0, 1, 0,0,0,0,0,0);  // edge 10 samples low
    add(0,1,0, 1, 0,0,0,0,0,0);  // edge 11 samples high again
    add(0,1,0, 9, 0,0,0,0,0,0);  // edge 20
    add(0,1,0, 1, 0,1,1,0,0,0);  // edge 21

    #2;
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      lock_raw = vecs[i].lock;
      restart  = vecs[i].rs;
      for (int k = 0; k < vecs[i].n; k++) begin
        tick();
        restart = 1'b0;
      end
      chk($sformatf("vec%0d_pll_reset", i), int'(pll_reset), int'(vecs[i].p));
      chk($sformatf("vec%0d_sys_rst_n", i), int'(sys_rst_n), int'(vecs[i].s));
      chk($sformatf("vec%0d_locked", i),    int'(locked),    int'(vecs[i].l));
      chk($sformatf("vec%0d_fail", i),      int'(fail),      int'(vecs[i].f));
      chk($sformatf("vec%0d_retry", i),     int'(retry_cnt), vecs[i].r);
      chk($sformatf("vec%0d_loss", i),      int'(loss_cnt),  vecs[i].loss);
    end

    // 300 forced lock losses: loss_cnt saturates
    do_reset();
    for (int i = 0; i < 300; i++) begin
      lock_raw = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin tick(); ok = locked; end
      if (!ok) begin n_checks++; n_fail++; $display("FAIL sat_lock_timeout iter %0d", i); break; end
      lock_raw = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 6 && !ok; c++) begin tick(); ok = !locked; end
      if (!ok) begin n_checks++; n_fail++; $display("FAIL sat_loss_timeout iter %0d", i); break; end
    end
    chk("loss_saturated", int'(loss_cnt), 255);

    // Async reset while in STABLE
    lock_raw = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("pre_rst_pll_reset", int'(pll_reset), 0);
    chk("pre_rst_sys_rst_n", int'(sys_rst_n), 0);
    #2;
    do_reset();

    // Randomized lock runs with occasional restart
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        lock_raw = 1'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 30));
      end
      run_left--;
      restart = ($urandom_range(0, 63) == 0);
      tick();
    end
    restart = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
